pwr_up_seq: RTL and testbench

Power-up sequencer directly downstream of the reset synchronizer in the Segway design. After the synchronized reset releases, it waits a fixed settle time for the sensors and supplies. It then requests inertial-sensor initialization and watches for completion with a timeout and bounded retries. Only after completion does it release the system enable that gates the balance controller and motor drive. It reports a latched failure if initialization never completes.

---
 rtl/pwr_up_seq.sv | 140 ++++++++++++++
 tb/tb_pwr_up_seq.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwr_up_seq.sv
// pwr_up_seq
//   Power-up sequencer that sits after the reset synchronizer. After reset
//   release it waits SETTLE_CNT cycles for the supplies and sensors to settle.
//   It then strobes an inertial-sensor init request and waits up to
//   TIMEOUT_CNT cycles for init_done. It makes at most RETRY_MAX attempts.
//   On success it raises sys_en. If every attempt times out, it latches
//   init_fail. A single-cycle restart re-runs the whole sequence from any state.
//
// Parameters
//   SETTLE_CNT  : cycles spent settling before the first request (>= 1)
//   TIMEOUT_CNT : cycles allowed for init_done after each request (>= 1)
//   RETRY_MAX   : total init attempts before failure (>= 1)
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   init_done in   init complete from the inertial interface (level or pulse)
//   restart   in   synchronous one-cycle request to rerun the sequence
//   init_req  out  one-cycle init start strobe
//   sys_en    out  system enable, high only once init has completed
//   busy      out  high while settling, requesting or waiting
//   init_fail out  latched failure flag, high only after all attempts fail
module pwr_up_seq #(
  parameter int SETTLE_CNT  = 100000,
  parameter int TIMEOUT_CNT = 500000,
  parameter int RETRY_MAX   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init_done,
  input  logic restart,
  output logic init_req,
  output logic sys_en,
  output logic busy,
  output logic init_fail
);

  // One counter serves both the settle interval and the per-attempt timeout.
  // It is therefore sized for the longer of the two.
  localparam int CNT_MAX = (SETTLE_CNT > TIMEOUT_CNT) ? SETTLE_CNT : TIMEOUT_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ATT_W   = $clog2(RETRY_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CNT - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [ATT_W-1:0] ATT_ONE      = ATT_W'(1);
  localparam logic [ATT_W-1:0] ATT_LIMIT    = ATT_W'(RETRY_MAX);

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_REQ,
    ST_WAIT,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ATT_W-1:0] att, att_nxt;
  logic [ATT_W-1:0] att_inc;

  assign att_inc = att + ATT_ONE;

  // Next-state logic. Restart overrides every state. In WAIT, a completion
  // that arrives in the same cycle as the timeout still wins and goes to RUN.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    att_nxt   = att;
    if (restart) begin
      state_nxt = ST_SETTLE;
      cnt_nxt   = '0;
      att_nxt   = '0;
    end else begin
      case (state)
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state_nxt = ST_REQ;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        ST_REQ: begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end
        ST_WAIT: begin
          if (init_done) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            att_nxt = att_inc;
            cnt_nxt = '0;
            if (att_inc == ATT_LIMIT) begin
              state_nxt = ST_FAIL;
            end else begin
              state_nxt = ST_REQ;
            end
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        ST_RUN:  state_nxt = ST_RUN;
        ST_FAIL: state_nxt = ST_FAIL;
        default: begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
          att_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered. This way they
  // change on the same edge as the state and carry no decode glitches.
  // Reset leaves busy high because the sequencer starts in SETTLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SETTLE;
      cnt       <= '0;
      att       <= '0;
      init_req  <= 1'b0;
      sys_en    <= 1'b0;
      busy      <= 1'b1;
      init_fail <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      att       <= att_nxt;
      init_req  <= (state_nxt == ST_REQ);
      sys_en    <= (state_nxt == ST_RUN);
      busy      <= (state_nxt == ST_SETTLE) || (state_nxt == ST_REQ) ||
                   (state_nxt == ST_WAIT);
      init_fail <= (state_nxt == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_pwr_up_seq.sv
// tb_pwr_up_seq
//   Self-checking bench for pwr_up_seq with SETTLE_CNT=8, TIMEOUT_CNT=16,
//   RETRY_MAX=3. The reference model tracks only the elapsed time since the
//   sequence started and whether init has completed. It derives the expected
//   phase from the timeline arithmetic: settle, then RETRY_MAX slots of
//   (1 request + TIMEOUT_CNT wait) cycles, then failure.
//   Cycle k is observed at the falling edge just before rising edge k.
//   Inputs for cycle k are driven at that same falling edge.
module tb_pwr_up_seq;

  localparam int S      = 8;
  localparam int T      = 16;
  localparam int R      = 3;
  localparam int SLOT   = T + 1;
  localparam int FAIL_T = S + R * SLOT;

  logic clk;
  logic rst_n;
  logic init_done;
  logic restart;
  logic init_req;
  logic sys_en;
  logic busy;
  logic init_fail;

  int n_cmp = 0;
  int n_bad = 0;

  int m_t   = 0;
  bit m_run = 1'b0;

  pwr_up_seq #(
    .SETTLE_CNT (S),
    .TIMEOUT_CNT(T),
    .RETRY_MAX  (R)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_done(init_done),
    .restart  (restart),
    .init_req (init_req),
    .sys_en   (sys_en),
    .busy     (busy),
    .init_fail(init_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop so that a broken build cannot hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired got=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Expected {init_req, sys_en, busy, init_fail} for the current cycle.
  function automatic logic [3:0] model_out();
    if (m_run)                   return 4'b0100;
    if (m_t < S)                 return 4'b0010;
    if (m_t >= FAIL_T)           return 4'b0001;
    if (((m_t - S) % SLOT) == 0) return 4'b1010;
    return 4'b0010;
  endfunction

  function automatic bit model_waiting();
    return !m_run && (m_t >= S) && (m_t < FAIL_T) && (((m_t - S) % SLOT) != 0);
  endfunction

  task automatic model_step(input logic d, input logic r);
    if (r) begin
      m_t   = 0;
      m_run = 1'b0;
    end else if (!m_run) begin
      if (model_waiting() && d) m_run = 1'b1;
      else if (m_t < FAIL_T)    m_t = m_t + 1;
    end
  endtask

  task automatic tick(input logic d, input logic r);
    init_done = d;
    restart   = r;
    @(posedge clk);
    model_step(d, r);
    @(negedge clk);
    init_done = 1'b0;
    restart   = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_t   = 0;
    m_run = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rst_n = 1'b0; init_done = 1'b0; restart = 1'b0;
    #12;
    n_cmp++;
    if ({init_req, sys_en, busy, init_fail} !== 4'b0010) begin
      n_bad++;
      $display("[TB] FAIL reset_vals got=%b required=0010", {init_req, sys_en, busy, init_fail});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({init_req, sys_en, busy, init_fail} !== 4'b0010) begin
      n_bad++;
      $display("[TB] FAIL reset_hold got=%b required=0010", {init_req, sys_en, busy, init_fail});
    end
    @(negedge clk);
    rst_n = 1'b1; m_t = 0; m_run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp = model_out();
      n_cmp++;
      if ({init_req, sys_en, busy, init_fail} !== exp) begin
        n_bad++;
        $display("[TB] FAIL reset_seq cyc=%0d got=%b required=%b", k, {init_req, sys_en, busy, init_fail}, exp);
      end
      tick(1'b0, 1'b0);
    end
  endtask

  task automatic test_nominal();
    logic [3:0] exp;
    apply_reset();
    for (int k = 0; k < 25; k++) begin
      exp = model_out();
      n_cmp++;
      if ({init_req, sys_en, busy, init_fail} !== exp) begin
        n_bad++;
        $display("[TB] FAIL nominal cyc=%0d got=%b required=%b", k, {init_req, sys_en, busy, init_fail}, exp);
      end
      if (k == 8 || k == 14) begin
        n_cmp++;
        if ({init_req, sys_en} !== ((k == 8) ? 2'b10 : 2'b01)) begin
          n_bad++;
          $display("[TB] FAIL nominal_point cyc=%0d got=%b required=%b", k, {init_req, sys_en}, (k == 8) ? 2'b10 : 2'b01);
        end
      end
      tick(k == 13, 1'b0);
    end
  endtask

  task automatic test_no_response();
    logic [3:0] exp;
    apply_reset();
    for (int k = 0; k < 80; k++) begin
      exp = model_out();
      n_cmp++;
      if ({init_req, sys_en, busy, init_fail} !== exp) begin
        n_bad++;
        $display("[TB] FAIL no_resp cyc=%0d got=%b required=%b", k, {init_req, sys_en, busy, init_fail}, exp);
      end
      if (k == 42 || k == 58 || k == 59) begin
        n_cmp++;
        if ({busy, init_fail} !== ((k == 59) ? 2'b01 : 2'b10)) begin
          n_bad++;
          $display("[TB] FAIL no_resp_point cyc=%0d got=%b required=%b", k, {busy, init_fail}, (k == 59) ? 2'b01 : 2'b10);
        end
      end
      tick(1'b0, 1'b0);
    end
  endtask

  task automatic test_boundary();
    logic [3:0] exp;
    for (int s = 0; s < 2; s++) begin
      apply_reset();
      for (int k = 0; k < 40; k++) begin
        exp = model_out();
        n_cmp++;
        if ({init_req, sys_en, busy, init_fail} !== exp) begin
          n_bad++;
          $display("[TB] FAIL boundary%0d cyc=%0d got=%b required=%b", s, k, {init_req, sys_en, busy, init_fail}, exp);
        end
        if (k == 25) begin
          n_cmp++;
          if ({init_req, sys_en} !== ((s == 0) ? 2'b01 : 2'b10)) begin
            n_bad++;
            $display("[TB] FAIL boundary%0d_c25 got=%b required=%b", s, {init_req, sys_en}, (s == 0) ? 2'b01 : 2'b10);
          end
        end
        tick((s == 0) ? (k == 24) : (k == 8), 1'b0);
      end
    end
  endtask

  task automatic test_restart();
    logic [3:0] exp;
    apply_reset();
    for (int k = 0; k < 112; k++) begin
      exp = model_out();
      n_cmp++;
      if ({init_req, sys_en, busy, init_fail} !== exp) begin
        n_bad++;
        $display("[TB] FAIL restart cyc=%0d got=%b required=%b", k, {init_req, sys_en, busy, init_fail}, exp);
      end
      if (k == 31 || k == 39 || k == 90 || k == 96 || k == 104) begin
        n_cmp++;
        if ({init_req, init_fail} !== ((k == 90) ? 2'b01 : (k == 39 || k == 104) ? 2'b10 : 2'b00)) begin
          n_bad++;
          $display("[TB] FAIL restart_point cyc=%0d got=%b", k, {init_req, init_fail});
        end
      end
      tick(k == 13, (k == 30) || (k == 95));
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp;
    int rc;
    for (int s = 0; s < 3; s++) begin
      rc = (s == 0) ? 15 : (s == 1) ? 20 : 62;
      apply_reset();
      for (int k = 0; k < rc; k++) begin
        exp = model_out();
        n_cmp++;
        if ({init_req, sys_en, busy, init_fail} !== exp) begin
          n_bad++;
          $display("[TB] FAIL rst_mid%0d cyc=%0d got=%b required=%b", s, k, {init_req, sys_en, busy, init_fail}, exp);
        end
        tick((s == 1) && (k == 13), 1'b0);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({init_req, sys_en, busy, init_fail} !== 4'b0010) begin
        n_bad++;
        $display("[TB] FAIL rst_mid%0d_async got=%b required=0010", s, {init_req, sys_en, busy, init_fail});
      end
      @(posedge clk); #1;
      @(negedge clk);
      rst_n = 1'b1; m_t = 0; m_run = 1'b0;
      for (int k = 0; k < 12; k++) begin
        exp = model_out();
        n_cmp++;
        if ({init_req, sys_en, busy, init_fail} !== exp) begin
          n_bad++;
          $display("[TB] FAIL rst_mid%0d_after cyc=%0d got=%b required=%b", s, k, {init_req, sys_en, busy, init_fail}, exp);
        end
        tick(1'b0, 1'b0);
      end
    end
  endtask

  task automatic test_priority();
    logic [3:0] exp;
    apply_reset();
    for (int k = 0; k < 62; k++) begin
      exp = model_out();
      n_cmp++;
      if ({init_req, sys_en, busy, init_fail} !== exp) begin
        n_bad++;
        $display("[TB] FAIL priority cyc=%0d got=%b required=%b", k, {init_req, sys_en, busy, init_fail}, exp);
      end
      if (k == 14 || k == 39) begin
        n_cmp++;
        if ({init_req, sys_en, busy, init_fail} !== 4'b0010) begin
          n_bad++;
          $display("[TB] FAIL priority_point cyc=%0d got=%b required=0010", k, {init_req, sys_en, busy, init_fail});
        end
      end
      tick(k == 13, (k == 13) || (k == 38));
    end
  endtask

  task automatic test_random();
    logic [3:0] exp;
    int p;
    logic d, r;
    for (int round = 0; round < 5; round++) begin
      apply_reset();
      p = $urandom_range(0, 60);
      for (int k = 0; k < 300; k++) begin
        exp = model_out();
        n_cmp++;
        if ({init_req, sys_en, busy, init_fail} !== exp) begin
          n_bad++;
          $display("[TB] FAIL random r%0d cyc=%0d got=%b required=%b", round, k, {init_req, sys_en, busy, init_fail}, exp);
        end
        d = (int'($urandom_range(0, 999)) < p);
        r = ($urandom_range(0, 99) == 0);
        tick(d, r);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; init_done = 1'b0; restart = 1'b0;
    test_reset();
    test_nominal();
    test_no_response();
    test_boundary();
    test_restart();
    test_reset_mid();
    test_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
